// File: rtl/iob2axi_wr_split_if.sv
// Bus bundle for iob2axi_wr_split: native read-side request port plus the AXI4 write channels.
// The master modport is the DMA engine side; the slave modport is the memory/source side.
interface iob2axi_wr_split_if #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int AXI_LEN_W = 8,
   parameter int AXI_ID_W  = 1
);
   logic                  m_valid;
   logic [ADDR_W-1:0]     m_addr;
   logic [DATA_W-1:0]     m_rdata;
   logic [DATA_W/8-1:0]   m_rstrb;
   logic                  m_ready;

   logic [AXI_ID_W-1:0]   m_axi_awid;
   logic [ADDR_W-1:0]     m_axi_awaddr;
   logic [AXI_LEN_W-1:0]  m_axi_awlen;
   logic [2:0]            m_axi_awsize;
   logic [1:0]            m_axi_awburst;
   logic                  m_axi_awlock;
   logic [3:0]            m_axi_awcache;
   logic [2:0]            m_axi_awprot;
   logic [3:0]            m_axi_awqos;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;

   logic [DATA_W-1:0]     m_axi_wdata;
   logic [DATA_W/8-1:0]   m_axi_wstrb;
   logic                  m_axi_wlast;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;

   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;

   modport master (
      output m_valid, m_addr,
      input  m_rdata, m_rstrb, m_ready,
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready
   );

   modport slave (
      input  m_valid, m_addr,
      output m_rdata, m_rstrb, m_ready,
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready
   );
endinterface

// File: rtl/iob2axi_wr_split.sv
// Native-to-AXI4 write DMA: fetches LEN words from a native source and writes them as INCR bursts,
// each at most MAX_BURST beats and never crossing a 4 KB page; one burst outstanding at a time.
module iob2axi_wr_split #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int AXI_LEN_W = 8,
   parameter int AXI_ID_W  = 1,
   parameter int AXI_ID    = 0,
   parameter int MAX_BURST = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [LEN_W-1:0]    length,
   output logic                ready,
   output logic                error,
   iob2axi_wr_split_if.master  bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int SHIFT = $clog2(BYTES);
   localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~ADDR_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0]  WORD_STEP  = ADDR_W'(BYTES);
   localparam logic [AXI_LEN_W:0] ONE_BEAT   = (AXI_LEN_W+1)'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   // Beats allowed from a word-aligned page offset: min(remaining, MAX_BURST, words left in the 4 KB page).
   function automatic logic [AXI_LEN_W:0] burst_calc(input logic [11:0] page_off,
                                                     input logic [LEN_W-1:0] rem);
      logic [31:0] page_words;
      logic [31:0] b;
      page_words = (32'd4096 - {20'd0, page_off}) >> SHIFT;
      b = 32'(rem);
      if (b > 32'(MAX_BURST)) b = 32'(MAX_BURST);
      if (b > page_words) b = page_words;
      return (AXI_LEN_W+1)'(b);
   endfunction

   logic [1:0]           state;
   logic [ADDR_W-1:0]    burst_addr;
   logic [LEN_W-1:0]     remaining;
   logic [AXI_LEN_W:0]   beats;
   logic [AXI_LEN_W:0]   fetched;
   logic [AXI_LEN_W-1:0] aw_len;
   logic                 aw_valid;
   logic [ADDR_W-1:0]    rd_addr;
   logic                 buf_full;
   logic                 buf_last;
   logic [DATA_W-1:0]    buf_data;
   logic [BYTES-1:0]     buf_strb;
   logic                 b_ready;

   logic                 pop;
   logic                 fetch_en;
   logic                 fetch;
   logic [ADDR_W-1:0]    start_addr;
   logic [ADDR_W-1:0]    next_addr;
   logic [LEN_W-1:0]     next_rem;
   logic [AXI_LEN_W:0]   first_beats;
   logic [AXI_LEN_W:0]   next_beats;

   assign pop         = buf_full & bus.m_axi_wready;
   // The buffer may be refilled in the same cycle it drains, which sustains one beat per cycle.
   assign fetch_en    = (state == S_DATA) && (fetched < beats) && (!buf_full || pop);
   assign fetch       = fetch_en & bus.m_ready;
   assign start_addr  = addr & ALIGN_MASK;
   assign next_addr   = burst_addr + (ADDR_W'(beats) << SHIFT);
   assign next_rem    = remaining - LEN_W'(beats);
   assign first_beats = burst_calc(start_addr[11:0], length);
   assign next_beats  = burst_calc(next_addr[11:0], next_rem);

   // Transfer sequencing, burst sizing, data buffer and response accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ready      <= 1'b1;
         error      <= 1'b0;
         burst_addr <= '0;
         remaining  <= '0;
         beats      <= '0;
         fetched    <= '0;
         aw_len     <= '0;
         aw_valid   <= 1'b0;
         rd_addr    <= '0;
         buf_full   <= 1'b0;
         buf_last   <= 1'b0;
         buf_data   <= '0;
         buf_strb   <= '0;
         b_ready    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  error <= 1'b0;
                  if (length != '0) begin
                     ready      <= 1'b0;
                     burst_addr <= start_addr;
                     rd_addr    <= start_addr;
                     remaining  <= length;
                     beats      <= first_beats;
                     aw_len     <= AXI_LEN_W'(first_beats - ONE_BEAT);
                     aw_valid   <= 1'b1;
                     state      <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (bus.m_axi_awready) begin
                  aw_valid <= 1'b0;
                  fetched  <= '0;
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (fetch) begin
                  buf_full <= 1'b1;
                  buf_last <= ((fetched + ONE_BEAT) == beats);
                  buf_data <= bus.m_rdata;
                  buf_strb <= bus.m_rstrb;
                  fetched  <= fetched + ONE_BEAT;
                  rd_addr  <= rd_addr + WORD_STEP;
               end else if (pop) begin
                  buf_full <= 1'b0;
                  buf_last <= 1'b0;
               end
               if (pop && buf_last) begin
                  b_ready <= 1'b1;
                  state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.m_axi_bvalid) begin
                  error      <= error | (bus.m_axi_bresp != 2'b00);
                  b_ready    <= 1'b0;
                  burst_addr <= next_addr;
                  remaining  <= next_rem;
                  if (next_rem == '0) begin
                     ready <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     rd_addr  <= next_addr;
                     beats    <= next_beats;
                     aw_len   <= AXI_LEN_W'(next_beats - ONE_BEAT);
                     aw_valid <= 1'b1;
                     state    <= S_ADDR;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.m_valid       = fetch_en;
   assign bus.m_addr        = rd_addr;

   assign bus.m_axi_awid    = AXI_ID_W'(AXI_ID);
   assign bus.m_axi_awaddr  = burst_addr;
   assign bus.m_axi_awlen   = aw_len;
   assign bus.m_axi_awsize  = 3'(SHIFT);
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awlock  = 1'b0;
   assign bus.m_axi_awcache = 4'b0010;
   assign bus.m_axi_awprot  = 3'b010;
   assign bus.m_axi_awqos   = 4'b0000;
   assign bus.m_axi_awvalid = aw_valid;

   assign bus.m_axi_wdata   = buf_data;
   assign bus.m_axi_wstrb   = buf_strb;
   assign bus.m_axi_wlast   = buf_last;
   assign bus.m_axi_wvalid  = buf_full;

   assign bus.m_axi_bready  = b_ready;
endmodule
